ps2_keyboard: RTL and testbench

- PS/2 keyboard receiver that sits directly upstream of the game controller.
- Synchronises and filters the raw ps2_clk/ps2_data lines, then deframes 11-bit device-to-host frames.
- Decodes the E0 (extended) and F0 (break) prefixes into one event per key.
- Keeps held-key level flags for the arrow keys and space, which game logic samples directly.

---
 rtl/ps2_keyboard.sv | 191 +++++++++++++++++++
 tb/tb_ps2_keyboard.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: line sync/filter, 11-bit frame deframing, E0/F0 prefix decode, held-key flags.
// Optional macro PS2_PARITY_CHECK_EN: when defined, frames with bad odd parity are discarded.
module ps2_keyboard #(
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_brk,
  output logic       key_valid,
  output logic       frame_err,
  output logic       key_up,
  output logic       key_down,
  output logic       key_left,
  output logic       key_right,
  output logic       key_space
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);

  logic [1:0]    clk_sync_r;
  logic [1:0]    data_sync_r;
  logic [FW-1:0] filt_cnt_r;
  logic          clk_filt_r;
  logic          clk_filt_d_r;
  logic [1:0]    state_r;
  logic [2:0]    bit_cnt_r;
  logic [7:0]    shift_r;
  logic [TW-1:0] to_cnt_r;
  logic          ext_r;
  logic          brk_r;
  logic          fall_s;
  logic          rx_bit_s;
  logic          timeout_s;
  logic          frame_ok_s;

`ifdef PS2_PARITY_CHECK_EN
  logic par_r;

  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

  assign frame_ok_s = rx_bit_s & odd_parity_ok(shift_r, par_r);
`else
  assign frame_ok_s = rx_bit_s;
`endif

  assign fall_s    = clk_filt_d_r & ~clk_filt_r;
  assign rx_bit_s  = data_sync_r[1];
  assign timeout_s = (state_r != S_IDLE) && !fall_s && (to_cnt_r == TO_LAST);

  // Two-flop synchronisers, reset to the idle-high line level so reset cannot fake a fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_r  <= 2'b11;
      data_sync_r <= 2'b11;
    end else begin
      clk_sync_r  <= {clk_sync_r[0], ps2_clk};
      data_sync_r <= {data_sync_r[0], ps2_data};
    end
  end

  // Glitch filter: the filtered clock follows only a level held for FILTER_LEN samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_cnt_r   <= {FW{1'b0}};
      clk_filt_r   <= 1'b1;
      clk_filt_d_r <= 1'b1;
    end else begin
      clk_filt_d_r <= clk_filt_r;
      if (clk_sync_r[1] == clk_filt_r) begin
        filt_cnt_r <= {FW{1'b0}};
      end else if (filt_cnt_r == FILT_LAST) begin
        filt_cnt_r <= {FW{1'b0}};
        clk_filt_r <= clk_sync_r[1];
      end else begin
        filt_cnt_r <= filt_cnt_r + FW'(1);
      end
    end
  end

  // Frame FSM, prefix tracking, event outputs and held-key flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= S_IDLE;
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'h00;
      to_cnt_r  <= {TW{1'b0}};
      ext_r     <= 1'b0;
      brk_r     <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_r     <= 1'b0;
`endif
      key_code  <= 8'h00;
      key_ext   <= 1'b0;
      key_brk   <= 1'b0;
      key_valid <= 1'b0;
      frame_err <= 1'b0;
      key_up    <= 1'b0;
      key_down  <= 1'b0;
      key_left  <= 1'b0;
      key_right <= 1'b0;
      key_space <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      frame_err <= 1'b0;
      if (timeout_s) begin
        state_r   <= S_IDLE;
        bit_cnt_r <= 3'd0;
        shift_r   <= 8'h00;
        to_cnt_r  <= {TW{1'b0}};
        ext_r     <= 1'b0;
        brk_r     <= 1'b0;
        frame_err <= 1'b1;
      end else begin
        if (state_r == S_IDLE || fall_s) begin
          to_cnt_r <= {TW{1'b0}};
        end else begin
          to_cnt_r <= to_cnt_r + TW'(1);
        end
        if (fall_s) begin
          case (state_r)
            S_IDLE: begin
              if (!rx_bit_s) begin
                state_r   <= S_DATA;
                bit_cnt_r <= 3'd0;
                shift_r   <= 8'h00;
              end
            end
            S_DATA: begin
              shift_r   <= {rx_bit_s, shift_r[7:1]};
              bit_cnt_r <= bit_cnt_r + 3'd1;
              if (bit_cnt_r == 3'd7) begin
                state_r <= S_PARITY;
              end
            end
            S_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
              par_r   <= rx_bit_s;
`endif
              state_r <= S_STOP;
            end
            S_STOP: begin
              state_r <= S_IDLE;
              if (!frame_ok_s) begin
                frame_err <= 1'b1;
                ext_r     <= 1'b0;
                brk_r     <= 1'b0;
              end else if (shift_r == 8'hE0) begin
                ext_r <= 1'b1;
              end else if (shift_r == 8'hF0) begin
                brk_r <= 1'b1;
              end else begin
                key_code  <= shift_r;
                key_ext   <= ext_r;
                key_brk   <= brk_r;
                key_valid <= 1'b1;
                ext_r     <= 1'b0;
                brk_r     <= 1'b0;
                // Held flags: only extended arrows and plain space are tracked.
                case ({ext_r, shift_r})
                  9'h175:  key_up    <= ~brk_r;
                  9'h172:  key_down  <= ~brk_r;
                  9'h16B:  key_left  <= ~brk_r;
                  9'h174:  key_right <= ~brk_r;
                  9'h029:  key_space <= ~brk_r;
                  default: ;
                endcase
              end
            end
            default: state_r <= S_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyboard.sv
// Self-checking bench for ps2_keyboard: directed scenarios plus random byte streams against a byte-level model.
module tb_ps2_keyboard;

  localparam int TO_CYC = 200;
  localparam int HALF   = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] key_code;
  logic       key_ext, key_brk, key_valid, frame_err;
  logic       key_up, key_down, key_left, key_right, key_space;
  logic [4:0] held_s;

  assign held_s = {key_space, key_right, key_left, key_down, key_up};

  always #5 clk = ~clk;

  ps2_keyboard #(.FILTER_LEN(4), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_code(key_code), .key_ext(key_ext), .key_brk(key_brk),
    .key_valid(key_valid), .frame_err(frame_err),
    .key_up(key_up), .key_down(key_down), .key_left(key_left),
    .key_right(key_right), .key_space(key_space)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse monitor: counts events, captures the event payload, flags pulses wider than one cycle.
  int vcnt = 0, ecnt = 0, wide = 0;
  logic [7:0] cap_code = 8'h00;
  logic cap_ext = 1'b0, cap_brk = 1'b0, valid_d = 1'b0, err_d = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      valid_d = 1'b0;
      err_d   = 1'b0;
    end else begin
      if (key_valid) begin
        vcnt++;
        cap_code = key_code;
        cap_ext  = key_ext;
        cap_brk  = key_brk;
        if (valid_d) wide++;
      end
      if (frame_err) begin
        ecnt++;
        if (err_d) wide++;
      end
      valid_d = key_valid;
      err_d   = frame_err;
    end
  end

  // Reference model at byte level.
  logic       m_ext = 1'b0, m_brk = 1'b0, m_kext = 1'b0, m_kbrk = 1'b0;
  logic [7:0] m_code = 8'h00;
  logic [4:0] m_held = 5'b0;

  function automatic int held_idx(input logic ext, input logic [7:0] c);
    if (ext && c == 8'h75) return 0;
    if (ext && c == 8'h72) return 1;
    if (ext && c == 8'h6B) return 2;
    if (ext && c == 8'h74) return 3;
    if (!ext && c == 8'h29) return 4;
    return -1;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    logic par;
    par = ~(^b) ^ bad_par;
    return {~bad_stop, par, b, 1'b0};
  endfunction

  task automatic do_frame(input string tag, input logic [7:0] b, input logic bad_par, input logic bad_stop);
    int v0, e0, idx;
    logic good, exp_v, exp_e;
    v0 = vcnt;
    e0 = ecnt;
    send_bits(make_frame(b, bad_par, bad_stop), 11);
    ps2_data = 1'b1;
    wait_cyc(30);
    good = !bad_stop;
`ifdef PS2_PARITY_CHECK_EN
    good = good && !bad_par;
`endif
    exp_v = 1'b0;
    exp_e = 1'b0;
    if (!good) begin
      exp_e = 1'b1;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      exp_v  = 1'b1;
      m_code = b;
      m_kext = m_ext;
      m_kbrk = m_brk;
      idx = held_idx(m_ext, b);
      if (idx >= 0) m_held[idx] = !m_brk;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
    check_eq({tag, ".valid_n"}, 32'(vcnt - v0), 32'(exp_v));
    check_eq({tag, ".err_n"}, 32'(ecnt - e0), 32'(exp_e));
    if (exp_v) check_eq({tag, ".cap"}, {22'd0, cap_ext, cap_brk, cap_code}, {22'd0, m_kext, m_kbrk, m_code});
    check_eq({tag, ".out"}, {22'd0, key_ext, key_brk, key_code}, {22'd0, m_kext, m_kbrk, m_code});
    check_eq({tag, ".held"}, {27'd0, held_s}, {27'd0, m_held});
  endtask

  task automatic model_reset();
    m_ext = 1'b0; m_brk = 1'b0; m_kext = 1'b0; m_kbrk = 1'b0;
    m_code = 8'h00; m_held = 5'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq(tag, {18'd0, key_code, key_ext, key_brk, key_valid, frame_err, held_s}, 32'd0);
  endtask

  initial begin
    int v0, e0;
    logic [7:0] pool [9];
    rst = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(5);
    check_all_zero("reset");
    rst = 1'b0;
    wait_cyc(10);

    do_frame("f1c", 8'h1C, 1'b0, 1'b0);

    v0 = vcnt;
    do_frame("up_e0", 8'hE0, 1'b0, 1'b0);
    do_frame("up_make", 8'h75, 1'b0, 1'b0);
    do_frame("up_e0b", 8'hE0, 1'b0, 1'b0);
    do_frame("up_f0", 8'hF0, 1'b0, 1'b0);
    do_frame("up_brk", 8'h75, 1'b0, 1'b0);
    check_eq("up_total", 32'(vcnt - v0), 32'd2);

    do_frame("sp_badpar", 8'h29, 1'b1, 1'b0);
    do_frame("badstop", 8'h1C, 1'b0, 1'b1);

    // Timeout after a partial frame must also drop a pending E0.
    do_frame("to_e0", 8'hE0, 1'b0, 1'b0);
    v0 = vcnt;
    e0 = ecnt;
    send_bits(make_frame(8'h74, 1'b0, 1'b0), 5);
    ps2_data = 1'b1;
    wait_cyc(TO_CYC + 10);
    m_ext = 1'b0;
    m_brk = 1'b0;
    check_eq("to_err", 32'(ecnt - e0), 32'd1);
    check_eq("to_valid", 32'(vcnt - v0), 32'd0);
    do_frame("to_74", 8'h74, 1'b0, 1'b0);

    // Reset in the middle of an E0 frame.
    do_frame("rs_e0", 8'hE0, 1'b0, 1'b0);
    do_frame("rs_up", 8'h75, 1'b0, 1'b0);
    do_frame("rs_e0b", 8'hE0, 1'b0, 1'b0);
    send_bits(make_frame(8'hE0, 1'b0, 1'b0), 4);
    rst = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(3);
    check_all_zero("rs_mid");
    model_reset();
    rst = 1'b0;
    wait_cyc(10);
    do_frame("rs_6b", 8'h6B, 1'b0, 1'b0);

    // Short clock glitches must be invisible.
    v0 = vcnt;
    e0 = ecnt;
    for (int i = 0; i < 6; i++) begin
      ps2_data = i[0];
      ps2_clk = 1'b0;
      wait_cyc(2);
      ps2_clk = 1'b1;
      wait_cyc(10);
    end
    ps2_data = 1'b1;
    wait_cyc(10);
    check_eq("gl_valid", 32'(vcnt - v0), 32'd0);
    check_eq("gl_err", 32'(ecnt - e0), 32'd0);
    check_eq("gl_out", {22'd0, key_ext, key_brk, key_code}, {22'd0, m_kext, m_kbrk, m_code});
    do_frame("gl_1c", 8'h1C, 1'b0, 1'b0);

    pool[0] = 8'hE0; pool[1] = 8'hF0; pool[2] = 8'h75; pool[3] = 8'h72;
    pool[4] = 8'h6B; pool[5] = 8'h74; pool[6] = 8'h29; pool[7] = 8'hE0;
    for (int n = 0; n < 50; n++) begin
      int k;
      logic [7:0] b;
      k = $urandom_range(0, 9);
      if (k < 8) b = pool[k];
      else b = 8'($urandom);
      do_frame($sformatf("rnd%0d", n), b, ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
    end

    check_eq("pulse_width", 32'(wide), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
